// File: rtl/proc_pkg.sv
// +--------------------------------------------------------------------------+
// | proc_pkg : opcodes, step states and bus-select indices for practice-2    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package proc_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [2:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    HALT = 3'd4
  } step_e;

  localparam logic [2:0] ST_T0   = 3'd0;
  localparam logic [2:0] ST_T1   = 3'd1;
  localparam logic [2:0] ST_T2   = 3'd2;
  localparam logic [2:0] ST_T3   = 3'd3;
  localparam logic [2:0] ST_HALT = 3'd4;

  localparam int SEL_DIN = 0;
  localparam int SEL_R0  = 1;
  localparam int SEL_G   = 9;
  localparam int SEL_MEM = 10;

endpackage

`default_nettype wire

// File: rtl/reg_dec3to8.sv
// +--------------------------------------------------------------------------+
// | reg_dec3to8 : 3-to-8 one-hot register index decoder                      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module reg_dec3to8 (
  input  logic [2:0] idx,
  output logic [7:0] onehot
);

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign onehot[i] = (idx == 3'(i));
  end

endmodule

`default_nettype wire

// File: rtl/proc_control_fsm.sv
// +--------------------------------------------------------------------------+
// | proc_control_fsm : T0..T3 instruction sequencer driving the bus mux.     |
// | Option macro ILLEGAL_OP_TRAP_EN: opcode 111 traps into HALT (illegal=1). |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module proc_control_fsm
  import proc_pkg::*;
#(
  parameter int OPW  = 3,
  parameter int REGW = 3,
  parameter int SELW = 11
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   run,
  input  logic [OPW+2*REGW-1:0]  din,
  input  logic                   g_nz,
  output logic [SELW-1:0]        bus_sel,
  output logic [7:0]             r_in,
  output logic                   ir_in,
  output logic                   a_in,
  output logic                   g_in,
  output logic                   addsub,
  output logic                   addr_in,
  output logic                   mem_wr,
  output logic                   done
`ifdef ILLEGAL_OP_TRAP_EN
  ,
  output logic                   illegal
`endif
);

  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic [OPW+2*REGW-1:0] r_ir;
  logic [OPW-1:0]        w_op;
  logic [REGW-1:0]       w_x;
  logic [REGW-1:0]       w_y;
  logic [7:0]            w_x_oh;
  logic [7:0]            w_y_oh;
  logic                  w_trap;

  assign w_op = r_ir[OPW+2*REGW-1 -: OPW];
  assign w_x  = r_ir[2*REGW-1 -: REGW];
  assign w_y  = r_ir[REGW-1:0];

  reg_dec3to8 u_dec_x (.idx(w_x), .onehot(w_x_oh));
  reg_dec3to8 u_dec_y (.idx(w_y), .onehot(w_y_oh));

`ifdef ILLEGAL_OP_TRAP_EN
  assign w_trap  = (r_state == ST_T1) && (w_op == OP_RSVD);
  assign illegal = (r_state == ST_HALT);
`else
  assign w_trap  = 1'b0;
`endif

  always_comb begin
    bus_sel = '0;
    r_in    = '0;
    ir_in   = 1'b0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    addsub  = 1'b0;
    addr_in = 1'b0;
    mem_wr  = 1'b0;
    done    = 1'b0;
    case (r_state)
      // Gated by resetn so the fetch strobe stays low while reset is held.
      ST_T0: ir_in = run & resetn;
      ST_T1: begin
        case (w_op)
          OP_MV: begin
            bus_sel[SEL_R0 +: 8] = w_y_oh;
            r_in = w_x_oh;
            done = 1'b1;
          end
          OP_MVI: begin
            bus_sel[SEL_DIN] = 1'b1;
            r_in = w_x_oh;
            done = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            bus_sel[SEL_R0 +: 8] = w_x_oh;
            a_in = 1'b1;
          end
          OP_LD, OP_ST: begin
            bus_sel[SEL_R0 +: 8] = w_y_oh;
            addr_in = 1'b1;
          end
          OP_MVNZ: begin
            if (g_nz) begin
              bus_sel[SEL_R0 +: 8] = w_y_oh;
              r_in = w_x_oh;
            end
            done = 1'b1;
          end
          default: done = ~w_trap;
        endcase
      end
      ST_T2: begin
        case (w_op)
          OP_ADD, OP_SUB: begin
            bus_sel[SEL_R0 +: 8] = w_y_oh;
            g_in   = 1'b1;
            addsub = (w_op == OP_SUB);
          end
          OP_LD: begin
            bus_sel[SEL_MEM] = 1'b1;
            r_in = w_x_oh;
            done = 1'b1;
          end
          OP_ST: begin
            bus_sel[SEL_R0 +: 8] = w_x_oh;
            mem_wr = 1'b1;
            done   = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T3: begin
        bus_sel[SEL_G] = 1'b1;
        r_in = w_x_oh;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next = ST_T0;
    case (r_state)
      ST_T0:   w_next = run ? ST_T1 : ST_T0;
      ST_T1:   w_next = w_trap ? ST_HALT : (done ? ST_T0 : ST_T2);
      ST_T2:   w_next = done ? ST_T0 : ST_T3;
      ST_T3:   w_next = ST_T0;
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_T0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_T0;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_T0 && run) begin
        r_ir <= din;
      end
    end
  end

endmodule

`default_nettype wire
